// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and predicts the next one with a small
// direct-mapped BTB holding 2-bit saturating counters. Execute-stage
// resolution detects mispredicts, raises flush and redirects the PC, and
// trains the BTB.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   stall             hold PC (fetch backpressure); a redirect still wins
//   pc                current fetch PC
//   pred_taken        prediction for pc (travels down the pipe)
//   pred_target       predicted next PC for pc (travels down the pipe)
//   ex_*              execute-stage resolution of one instruction
//   flush             combinational: kill IF/ID this cycle
//
// Optional build macro PC_SEQ_PERF_EN adds saturating 32-bit counters
// perf_branches and perf_mispredicts.
module pc_sequencer #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int              IDX_W  = $clog2(BTB_ENTRIES);
  localparam int              TAG_W  = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btb_ent_t;

  // Valid bits need reset; payload does not.
  logic [BTB_ENTRIES-1:0] btb_vld;
  btb_ent_t               btb_mem [BTB_ENTRIES];

  // ---------------- fetch-side lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  btb_ent_t         f_ent;
  logic             f_hit;

  assign f_idx       = pc[IDX_W+1:2];
  assign f_tag       = pc[XLEN-1:IDX_W+2];
  assign f_ent       = btb_mem[f_idx];
  assign f_hit       = btb_vld[f_idx] && (f_ent.tag == f_tag);
  assign pred_taken  = f_hit && f_ent.ctr[1];
  assign pred_target = pred_taken ? f_ent.target : pc + PC_INC;

  // ---------------- execute-side resolution ----------------
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  btb_ent_t         e_ent;
  logic             e_hit;
  logic             actual_taken;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict;

  assign e_idx        = ex_pc[IDX_W+1:2];
  assign e_tag        = ex_pc[XLEN-1:IDX_W+2];
  assign e_ent        = btb_mem[e_idx];
  assign e_hit        = btb_vld[e_idx] && (e_ent.tag == e_tag);
  assign actual_taken = ex_is_jump | (ex_is_branch & ex_taken);
  assign actual_next  = actual_taken ? ex_target : ex_pc + PC_INC;
  // A non-control instruction predicted taken (stale entry) falls out here
  // too: actual_taken=0 differs from ex_pred_taken=1.
  assign mispredict   = ex_valid &&
                        ((actual_taken != ex_pred_taken) ||
                         (actual_taken && (ex_target != ex_pred_target)));
  assign flush        = mispredict;

  // ---------------- BTB update decision ----------------
  logic [1:0] ctr_nxt;
  logic       upd_we;
  logic       upd_clr;
  btb_ent_t   upd_ent;

  always_comb begin
    ctr_nxt = e_ent.ctr;
    if (ex_taken) begin
      if (e_ent.ctr != 2'b11) ctr_nxt = e_ent.ctr + 2'd1;
    end else begin
      if (e_ent.ctr != 2'b00) ctr_nxt = e_ent.ctr - 2'd1;
    end
  end

  always_comb begin
    upd_we  = 1'b0;
    upd_clr = 1'b0;
    upd_ent = '{tag: e_tag, target: e_ent.target, ctr: e_ent.ctr};
    if (ex_valid) begin
      if (ex_is_jump) begin
        upd_we  = 1'b1;
        upd_ent = '{tag: e_tag, target: ex_target, ctr: 2'b11};
      end else if (ex_is_branch) begin
        if (e_hit) begin
          upd_we      = 1'b1;
          upd_ent.ctr = ctr_nxt;
          if (ex_taken) upd_ent.target = ex_target;
        end else if (ex_taken) begin
          // not-taken misses are never allocated
          upd_we  = 1'b1;
          upd_ent = '{tag: e_tag, target: ex_target, ctr: 2'b10};
        end
      end else if (ex_pred_taken && e_hit) begin
        upd_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          btb_vld        <= '0;
    else if (upd_we)  btb_vld[e_idx] <= 1'b1;
    else if (upd_clr) btb_vld[e_idx] <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_we) btb_mem[e_idx] <= upd_ent;
  end

  // ---------------- program counter ----------------
  always_ff @(posedge clk) begin
    if (rst)             pc <= RESET_PC;
    else if (mispredict) pc <= actual_next;
    else if (!stall)     pc <= pred_target;
  end

`ifdef PC_SEQ_PERF_EN
  logic br_evt;
  assign br_evt = ex_valid & (ex_is_branch | ex_is_jump);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (br_evt && perf_branches != 32'hFFFF_FFFF)
        perf_branches <= perf_branches + 32'd1;
      if (mispredict && perf_mispredicts != 32'hFFFF_FFFF)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model of the
// BTB (array of entries indexed arithmetically) and PC.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] pc, pred_target;
  logic        pred_taken, flush;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush)
`ifdef PC_SEQ_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_known = 0;
  logic [31:0] m_pc;
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic [31:0] m_pb, m_pm;

  always @(negedge clk) begin
    int          fi, ei;
    bit          fhit, ehit, ept, act, mis;
    logic [31:0] ept_tgt, nxt;
    fi      = int'((m_pc >> 2) % 16);
    fhit    = m_v[fi] && (m_tag[fi] == (m_pc >> 6));
    ept     = fhit && (m_ctr[fi] >= 2);
    ept_tgt = ept ? m_tgt[fi] : m_pc + 32'd4;
    act     = ex_is_jump || (ex_is_branch && ex_taken);
    nxt     = act ? ex_target : ex_pc + 32'd4;
    mis     = ex_valid && ((act != ex_pred_taken) || (act && ex_target != ex_pred_target));
    ei      = int'((ex_pc >> 2) % 16);
    ehit    = m_v[ei] && (m_tag[ei] == (ex_pc >> 6));
    if (m_known) begin
      chk("model_pc", pc, m_pc);
      chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, ept});
      chk("model_pred_target", pred_target, ept_tgt);
      chk("model_flush", {31'd0, flush}, {31'd0, mis});
`ifdef PC_SEQ_PERF_EN
      chk("model_perf_branches", perf_branches, m_pb);
      chk("model_perf_mispredicts", perf_mispredicts, m_pm);
`endif
    end
    if (rst) begin
      m_known = 1;
      m_pc    = 32'h0;
      m_pb    = 0;
      m_pm    = 0;
      for (int i = 0; i < 16; i++) m_v[i] = 0;
    end else if (m_known) begin
      if (mis)         m_pc = nxt;
      else if (!stall) m_pc = ept_tgt;
      if (ex_valid && (ex_is_branch || ex_is_jump) && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
      if (mis && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
      if (ex_valid) begin
        if (ex_is_jump) begin
          m_v[ei] = 1; m_tag[ei] = ex_pc >> 6; m_tgt[ei] = ex_target; m_ctr[ei] = 3;
        end else if (ex_is_branch) begin
          if (ehit) begin
            m_ctr[ei] = ex_taken ? ((m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3)
                                 : ((m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0);
            if (ex_taken) m_tgt[ei] = ex_target;
          end else if (ex_taken) begin
            m_v[ei] = 1; m_tag[ei] = ex_pc >> 6; m_tgt[ei] = ex_target; m_ctr[ei] = 2;
          end
        end else if (ex_pred_taken && ehit) begin
          m_v[ei] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0;
    ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic ex_drive(input logic br, input logic jp, input logic [31:0] epc,
                          input logic tk, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptg);
    ex_valid = 1; ex_is_branch = br; ex_is_jump = jp; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stall = 1; idle_ex();
    tick(); tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h4);
    rst = 0; stall = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("free_run_pc", pc, 32'(4 * i));
    end

    // cold taken branch at 0x10 -> 0x40
    ex_drive(1, 0, 32'h10, 1, 32'h40, 0, 32'h14); #1;
    chk("cold_flush", {31'd0, flush}, 32'd1);
    tick();
    chk("cold_redirect_pc", pc, 32'h40);
    ex_drive(0, 1, 32'h100, 1, 32'h10, 0, 32'h104);
    tick(); idle_ex(); #1;
    chk("cold_fetch_pc", pc, 32'h10);
    chk("cold_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("cold_pred_target", pred_target, 32'h40);

    // counter walk 10 -> 01 -> 00 -> 00, then taken -> 01
    ex_drive(1, 0, 32'h10, 0, 32'h40, 1, 32'h40); #1;
    chk("sat_nt1_flush", {31'd0, flush}, 32'd1);
    tick();
    chk("sat_nt1_pc", pc, 32'h14);
    ex_drive(1, 0, 32'h10, 0, 32'h40, 0, 32'h14); #1;
    chk("sat_nt2_flush", {31'd0, flush}, 32'd0);
    tick();
    ex_drive(1, 0, 32'h10, 0, 32'h40, 0, 32'h14); #1;
    chk("sat_nt3_flush", {31'd0, flush}, 32'd0);
    tick();
    ex_drive(1, 0, 32'h10, 1, 32'h40, 0, 32'h14); #1;
    chk("sat_tk_flush", {31'd0, flush}, 32'd1);
    tick();
    ex_drive(0, 1, 32'h100, 1, 32'h10, 0, 32'h104);
    tick(); idle_ex(); #1;
    chk("sat_fetch_pc", pc, 32'h10);
    chk("sat_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("sat_pred_target", pred_target, 32'h14);

    // stall vs redirect
    tick();
    stall = 1;
    ex_drive(0, 1, 32'h300, 1, 32'h200, 0, 32'h304);
    tick();
    chk("stall_redirect_pc", pc, 32'h200);
    idle_ex();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", pc, 32'h200);
    end
    stall = 0;

    // target mismatch at 0x20: trained to 0x40, actually 0x80
    ex_drive(1, 0, 32'h20, 1, 32'h40, 0, 32'h24);
    tick();
    ex_drive(1, 0, 32'h20, 1, 32'h80, 1, 32'h40); #1;
    chk("tgt_flush", {31'd0, flush}, 32'd1);
    tick();
    chk("tgt_pc", pc, 32'h80);
    ex_drive(0, 1, 32'h300, 1, 32'h20, 0, 32'h304);
    tick(); idle_ex(); #1;
    chk("tgt_fetch_pc", pc, 32'h20);
    chk("tgt_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("tgt_pred_target", pred_target, 32'h80);

    // wrap
    ex_drive(0, 1, 32'h300, 1, 32'hFFFF_FFFC, 0, 32'h304);
    tick(); idle_ex(); #1;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pred_target", pred_target, 32'h0);
    tick();
    chk("wrap_next_pc", pc, 32'h0);

    // stale entry at 0x10: retrain to taken, then non-branch predicted taken
    ex_drive(1, 0, 32'h10, 1, 32'h40, 0, 32'h14);
    tick();
    ex_drive(0, 0, 32'h10, 0, 32'h0, 1, 32'h40); #1;
    chk("stale_flush", {31'd0, flush}, 32'd1);
    tick();
    chk("stale_pc", pc, 32'h14);
    ex_drive(0, 1, 32'h300, 1, 32'h10, 0, 32'h304);
    tick(); idle_ex(); #1;
    chk("stale_fetch_pc", pc, 32'h10);
    chk("stale_pred_taken", {31'd0, pred_taken}, 32'd0);

    // ex_valid=0 ignores everything else
    ex_drive(0, 1, 32'h10, 1, 32'h999, 0, 32'h0);
    ex_valid = 0; #1;
    chk("novalid_flush", {31'd0, flush}, 32'd0);
    tick();
    chk("novalid_pc", pc, 32'h14);

    // reset beats mispredict and stall, BTB cleared
    ex_drive(0, 1, 32'h300, 1, 32'h500, 0, 32'h304);
    rst = 1; stall = 1;
    tick();
    rst = 0; stall = 0; idle_ex(); #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_pred_target", pred_target, 32'h4);
    ex_drive(0, 1, 32'h300, 1, 32'h20, 0, 32'h304);
    tick(); idle_ex(); #1;
    chk("midrst_fetch_pc", pc, 32'h20);
    chk("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
